// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder.
// The sub line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub input (A - B via ~B + 1).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_cat;

    assign fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    // The newest bit enters at the top; on the last edge this is the full sum.
    assign sum_cat  = {fa_sum, sum_sh_q};

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    carry_d = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
                    if (bus.sub) begin
                        b_sh_d  = ~bus.b_in;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_cat[WIDTH-1:1];
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_out_d = sum_cat;
                    cout_d    = fa_carry;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order. The shift registers
    // are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.sum_out = sum_out_q;
    assign bus.cout    = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for timing/handshake
// checks and a 4-bit instance swept exhaustively, both scored through queues.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) if4 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction

    // Scoreboard monitors: each done pulse pops one expected result.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) check("done8_unexpected", 32'(if8.done), 32'd0);
            else check("result8", 32'({if8.cout, if8.sum_out}), 32'(q8.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (if4.done === 1'b1) begin
            if (q4.size() == 0) check("done4_unexpected", 32'(if4.done), 32'd0);
            else check("result4", 32'({if4.cout, if4.sum_out}), 32'(q4.pop_front()));
        end
    end

    task automatic set_sub8(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        if8.sub = s;
`else
        if (s) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    // One 8-bit operation with latency, busy-length and hold checks.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        int lat;
        int busy_n;
        logic [8:0] exp;
        exp = model8(a, b, c, s);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a_in = a; if8.b_in = b; if8.cin = c; set_sub8(s);
        q8.push_back(exp);
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a_in = ~a; if8.b_in = 8'($urandom); if8.cin = ~c; set_sub8(~s);
        lat = -1;
        busy_n = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if8.busy === 1'b1) busy_n++;
            if (if8.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("latency8", 32'(lat), 32'd8);
        check("busy_cycles8", 32'(busy_n), 32'd9);
        @(negedge clk);
        check("busy_after_done", 32'(if8.busy), 32'd0);
        check("done_single", 32'(if8.done), 32'd0);
        check("sum_hold", 32'({if8.cout, if8.sum_out}), 32'(exp));
        set_sub8(1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        bit got;
        logic [7:0] ra, rb;
        logic rc;

        rst = 1'b1;
        if8.start = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.cin = 1'b0;
        if4.start = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        if8.sub = 1'b0;
        if4.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        // rst and start together: rst wins
        #1 if8.start = 1'b1; if8.a_in = 8'h11; if8.b_in = 8'h22;
        @(posedge clk); #1;
        if8.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(if8.busy), 32'd0);
        check("reset_done", 32'(if8.done), 32'd0);
        check("reset_sum", 32'(if8.sum_out), 32'd0);
        check("reset_cout", 32'(if8.cout), 32'd0);

        run_op8(8'h35, 8'h4A, 1'b0, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op8(8'h00, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
        run_op8(8'h10, 8'h20, 1'b0, 1'b1);
        run_op8(8'h20, 8'h10, 1'b1, 1'b1);
        run_op8(8'h5A, 8'h5A, 1'b0, 1'b1);
`endif

        // start held high for 30 edges: accepts only at E0, E10, E20
        @(posedge clk); #1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            if8.start = 1'b1; if8.a_in = ra; if8.b_in = rb; if8.cin = rc;
            @(posedge clk);
            if (c % 10 == 0) q8.push_back(model8(ra, rb, rc, 1'b0));
            @(negedge clk);
            if (if8.done === 1'b1) dones++;
        end
        if8.start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done === 1'b1) dones++;
        end
        check("handshake_dones", 32'(dones), 32'd3);
        check("handshake_queue_empty", 32'(q8.size()), 32'd0);

        // reset during the 4th SHIFT cycle aborts the operation
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a_in = 8'hC3; if8.b_in = 8'h5D; if8.cin = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(if8.busy), 32'd0);
        check("abort_done", 32'(if8.done), 32'd0);
        check("abort_sum", 32'(if8.sum_out), 32'd0);
        check("abort_cout", 32'(if8.cout), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op8(8'h9C, 8'h87, 1'b1, 1'b0);

        // WIDTH=4 exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(posedge clk); #1;
                    if4.start = 1'b1; if4.a_in = 4'(a); if4.b_in = 4'(b); if4.cin = 1'(c);
                    q4.push_back(model4(4'(a), 4'(b), 1'(c)));
                    @(posedge clk); #1;
                    if4.start = 1'b0; if4.a_in = 4'($urandom); if4.b_in = 4'($urandom);
                    got = 1'b0;
                    for (int n = 0; n < 20; n++) begin
                        @(negedge clk);
                        if (if4.done === 1'b1) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    if (!got) check("timeout4", 32'(got), 32'd1);
                end
            end
        end
        @(negedge clk);
        check("sweep_queue_empty", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer. One full-adder cell and a carry flip-flop compute a WIDTH-bit sum LSB-first, one bit per clock. The block owns the operand and result shift registers, the bit counter and the start/done handshake. It is the area-minimal alternative to a WIDTH-wide ripple adder in the arithmetic library.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- sub  input  1  present only with SERIAL_ADD_SUB_EN; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH  result; held until the next completion.
- cout  output  1  carry-out of bit WIDTH-1; held with sum_out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load a_sh=a_in, b_sh=b_in, carry=cin, cnt=0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each cycle:
  - s = a_sh[0]^b_sh[0]^carry
  - carry ← (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]))
  - a_sh, b_sh shift right by one.
  - s shifts into the MSB of sum_sh, which shifts right.
  - cnt++.
- SHIFT exit: when cnt==WIDTH-1, that edge also loads sum_out with the completed sum_sh (including the final bit) and cout with the final carry, then goes to DONE.
- DONE: done=1 for one cycle, then unconditionally to IDLE.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, exact in WIDTH+1 bits.
- cnt width is $clog2(WIDTH). Wrap-around never occurs because the exit condition is cnt==WIDTH-1.
- start in SHIFT or DONE is ignored and not queued.
- Changes to a_in, b_in, cin or sub after the accepting edge do not affect the result.
- sum_out and cout change only on the edge entering DONE (or on reset).

## Timing
- Accepting edge E0: IDLE with start=1.
- Edges E1..EW: the W bit operations. The EW edge enters DONE and registers the result.
- done is high between EW and EW+1.
- busy is high from E0 through EW+1.
- Earliest next acceptance is E(W+2), so throughput is one operation per WIDTH+2 cycles with start held high.
- Reset values: state IDLE, busy 0, done 0, sum_out 0, cout 0. Internal shift registers, carry and cnt all reset to 0.
- Reset mid-operation: the operation is aborted and state is IDLE after the reset edge. done never pulses for the aborted operation, and sum_out/cout are cleared.
- rst and start asserted together: rst wins; start is not accepted.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists.
  - sub=1 at acceptance: b_sh loads ~b_in, carry loads 1, cin is ignored.
  - Result: sum_out = (a_in - b_in) mod 2^WIDTH; cout=1 means no borrow (a_in ≥ b_in).
  - sub=0 behaves as a plain add.
- SERIAL_ADD_SUB_EN undefined: no sub port, add only, no subtract logic.

## Test plan
- Basic add (WIDTH=8): reset, then start with a=0x35, b=0x4A, cin=0 → done pulses exactly once, 8 cycles after the accepting edge; sum_out=0x7F, cout=0; busy high for 9 cycles.
- Carry extremes:
  - a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout=1.
  - a=0, b=0, cin=0 → 0x00, cout=0.
- Handshake: start held high for 30 cycles → accepts at E0, E10 and E20 only. Operand changes during busy do not alter results, and sum_out holds between done pulses.
- Reset mid-op: assert rst during the 4th SHIFT cycle → IDLE next cycle, busy=0, sum_out=0, no done. A fresh start then completes normally.
- Subtract (macro defined):
  - sub=1, a=0x10, b=0x20 → sum_out=0xF0, cout=0.
  - sub=1, a=0x20, b=0x10 → 0x10, cout=1.
  - sub=1, a=b=0x5A → 0x00, cout=1.
- Exhaustive: WIDTH=4, all 512 (a,b,cin) combinations compared against a+b+cin.
